// File: rtl/draw_sprite_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : draw_sprite_engine
// Brief    : Parametrised sprite blitter with screen-edge clipping, busy/done
//            handshake and sprite counter. Optional colour-key transparency
//            is enabled by defining SPRITE_TRANSPARENCY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module draw_sprite_engine #(
    parameter int SPR_W              = 16,
    parameter int SPR_H              = 16,
    parameter int X_W                = 9,
    parameter int Y_W                = 8,
    parameter int COLOUR_W           = 3,
    parameter int SCREEN_W           = 320,
    parameter int SCREEN_H           = 240,
    parameter int COUNT_W            = 8,
    parameter int TRANSPARENT_COLOUR = 0
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              start,
    input  logic [X_W-1:0]                    x_in,
    input  logic [Y_W-1:0]                    y_in,
    output logic [$clog2(SPR_W*SPR_H)-1:0]    rom_addr,
    input  logic [COLOUR_W-1:0]               rom_data,
    output logic [X_W-1:0]                    vga_x,
    output logic [Y_W-1:0]                    vga_y,
    output logic [COLOUR_W-1:0]               vga_colour,
    output logic                              writeEn,
    output logic                              busy,
    output logic                              done,
    output logic [COUNT_W-1:0]                sprite_count
);

    localparam int c_CX_W = $clog2(SPR_W);
    localparam int c_CY_W = $clog2(SPR_H);
    localparam logic [COLOUR_W-1:0] c_KEY = COLOUR_W'(TRANSPARENT_COLOUR);

`ifdef SPRITE_TRANSPARENCY_EN
    localparam logic c_KEY_EN = 1'b1;
`else
    localparam logic c_KEY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FETCH = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [c_CX_W-1:0]     r_cx;
    logic [c_CY_W-1:0]     r_cy;
    logic [X_W-1:0]        r_x0;
    logic [Y_W-1:0]        r_y0;
    logic [X_W-1:0]        r_vga_x;
    logic [Y_W-1:0]        r_vga_y;
    logic [COLOUR_W-1:0]   r_vga_colour;
    logic [COUNT_W-1:0]    r_count;

    logic [X_W:0]          w_sum_x;
    logic [Y_W:0]          w_sum_y;
    logic                  w_clip;
    logic                  w_key_hit;
    logic                  w_last;

    // One extra bit on each sum so off-screen positions never alias back on-screen.
    assign w_sum_x   = {1'b0, r_x0} + (X_W+1)'(r_cx);
    assign w_sum_y   = {1'b0, r_y0} + (Y_W+1)'(r_cy);
    assign w_clip    = (w_sum_x >= (X_W+1)'(SCREEN_W)) || (w_sum_y >= (Y_W+1)'(SCREEN_H));
    assign w_key_hit = c_KEY_EN && (rom_data == c_KEY);
    assign w_last    = (r_cx == c_CX_W'(SPR_W-1)) && (r_cy == c_CY_W'(SPR_H-1));

    assign rom_addr     = {r_cy, r_cx};
    assign sprite_count = r_count;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        writeEn    = 1'b0;
        busy       = (r_state != S_IDLE);
        done       = 1'b0;
        vga_x      = r_vga_x;
        vga_y      = r_vga_y;
        vga_colour = r_vga_colour;
        case (r_state)
            S_IDLE:  if (start) w_next = S_LOAD;
            S_LOAD:  w_next = S_FETCH;
            S_FETCH: w_next = S_WRITE;
            S_WRITE: begin
                // rom_data is only valid here, so the pixel bus is combinational in WRITE.
                vga_x      = w_sum_x[X_W-1:0];
                vga_y      = w_sum_y[Y_W-1:0];
                vga_colour = rom_data;
                writeEn    = !w_clip && !w_key_hit;
                w_next     = w_last ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cx         <= '0;
            r_cy         <= '0;
            r_x0         <= '0;
            r_y0         <= '0;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_count      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_x0 <= x_in;
                        r_y0 <= y_in;
                    end
                end
                S_LOAD: begin
                    r_cx <= '0;
                    r_cy <= '0;
                end
                S_WRITE: begin
                    r_vga_x      <= w_sum_x[X_W-1:0];
                    r_vga_y      <= w_sum_y[Y_W-1:0];
                    r_vga_colour <= rom_data;
                    // Power-of-two sprite dimensions let both counters wrap naturally.
                    r_cx         <= r_cx + c_CX_W'(1);
                    if (r_cx == c_CX_W'(SPR_W-1)) begin
                        r_cy <= r_cy + c_CY_W'(1);
                    end
                end
                S_DONE: begin
                    r_count <= r_count + COUNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_draw_sprite_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_draw_sprite_engine
// Brief    : Self-checking bench for draw_sprite_engine (16x16 main instance
//            plus a 4x2 instance for the sprite counter wrap).
// Revision : 1.0 - initial release
// ============================================================================
module tb_draw_sprite_engine;

    localparam int W   = 16;
    localparam int H   = 16;
    localparam int N   = W * H;
    localparam int SW  = 320;
    localparam int SH  = 240;
    localparam int KEY = 0;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [8:0] x_in = '0;
    logic [7:0] y_in = '0;
    logic [7:0] rom_addr;
    logic [2:0] rom_data = '0;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       writeEn;
    logic       busy;
    logic       done;
    logic [7:0] sprite_count;

    logic       s_start = 1'b0;
    logic [2:0] s_rom_addr;
    logic [2:0] s_rom_data;
    logic [8:0] s_vga_x;
    logic [7:0] s_vga_y;
    logic [2:0] s_vga_colour;
    logic       s_writeEn;
    logic       s_busy;
    logic       s_done;
    logic [7:0] s_count;

    logic [2:0] rom_mem [N];

    always #5 clk = ~clk;

    draw_sprite_engine u_dut (
        .clk          (clk),
        .resetn       (resetn),
        .start        (start),
        .x_in         (x_in),
        .y_in         (y_in),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_colour   (vga_colour),
        .writeEn      (writeEn),
        .busy         (busy),
        .done         (done),
        .sprite_count (sprite_count)
    );

    draw_sprite_engine #(.SPR_W(4), .SPR_H(2)) u_small (
        .clk          (clk),
        .resetn       (resetn),
        .start        (s_start),
        .x_in         (9'd0),
        .y_in         (8'd0),
        .rom_addr     (s_rom_addr),
        .rom_data     (s_rom_data),
        .vga_x        (s_vga_x),
        .vga_y        (s_vga_y),
        .vga_colour   (s_vga_colour),
        .writeEn      (s_writeEn),
        .busy         (s_busy),
        .done         (s_done),
        .sprite_count (s_count)
    );

    assign s_rom_data = 3'd0;

    // Synchronous colour ROM: data valid one cycle after the address.
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int  n_cmp = 0;
    int  n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Sprite-level model: m_k counts cycles since the accepting edge.
    bit m_act = 1'b0;
    int m_k = 0;
    int m_x0 = 0;
    int m_y0 = 0;
    int m_cnt = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_act = 1'b0;
            m_k   = 0;
            m_cnt = 0;
        end else if (m_act) begin
            if (m_k == 2*N+1) begin
                m_act = 1'b0;
                m_cnt = (m_cnt + 1) % 256;
            end else begin
                m_k++;
            end
        end else if (start) begin
            m_act = 1'b1;
            m_k   = 0;
            m_x0  = x_in;
            m_y0  = y_in;
        end
    end

    bit chk_en = 1'b0;
    int n_we = 0;
    int fw_x = -1;
    int fw_y = -1;
    int lx = 0;
    int ly = 0;
    int lc = 0;

    always @(negedge clk) begin
        int  pix, sx, sy, col;
        bit  wslot, expwe;
        if (chk_en) begin
            if (!resetn) begin
                chk("rst_writeEn", writeEn, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_count", sprite_count, 0);
                chk("rst_vga_x", vga_x, 0);
                chk("rst_rom_addr", rom_addr, 0);
                lx = 0; ly = 0; lc = 0;
            end else begin
                wslot = m_act && m_k >= 2 && m_k <= 2*N && (m_k % 2 == 0);
                chk("busy", busy, 32'(m_act));
                chk("done", done, 32'(m_act && m_k == 2*N+1));
                chk("sprite_count", sprite_count, m_cnt);
                if (m_act && m_k >= 1 && m_k <= 2*N)
                    chk("rom_addr", rom_addr, (m_k - 1) / 2);
                if (wslot) begin
                    pix   = (m_k - 2) / 2;
                    sx    = m_x0 + pix % W;
                    sy    = m_y0 + pix / W;
                    col   = rom_mem[pix];
                    expwe = (sx < SW) && (sy < SH);
`ifdef SPRITE_TRANSPARENCY_EN
                    if (col == KEY) expwe = 1'b0;
`endif
                    chk("writeEn", writeEn, 32'(expwe));
                    chk("vga_x", vga_x, sx % 512);
                    chk("vga_y", vga_y, sy % 256);
                    chk("vga_colour", vga_colour, col);
                    lx = sx % 512; ly = sy % 256; lc = col;
                end else begin
                    chk("writeEn_idle", writeEn, 0);
                    chk("vga_x_hold", vga_x, lx);
                    chk("vga_y_hold", vga_y, ly);
                    chk("vga_colour_hold", vga_colour, lc);
                end
            end
            if (writeEn === 1'b1) begin
                n_we++;
                if (m_k == 2) begin
                    fw_x = vga_x;
                    fw_y = vga_y;
                end
            end
        end
    end

    task automatic draw(input int x, input int y, input int p1, input int p2, input int rst_at,
                        output int writes, output int done_rel, output int n_done);
        int we0;
        @(negedge clk);
        x_in = 9'(x); y_in = 8'(y); start = 1'b1;
        we0 = n_we;
        done_rel = -1;
        n_done = 0;
        for (int r = 0; r <= 520; r++) begin
            @(negedge clk);
            start = (r == p1) || (r == p2);
            x_in  = 9'($urandom);
            y_in  = 8'($urandom);
            if (done === 1'b1) begin
                n_done++;
                if (done_rel < 0) done_rel = r;
            end
            if (r == rst_at) begin
                #2 resetn = 1'b0;
                #1;
                chk("async_rst_writeEn", writeEn, 0);
                chk("async_rst_busy", busy, 0);
                chk("async_rst_done", done, 0);
                chk("async_rst_count", sprite_count, 0);
                @(negedge clk);
                #2 resetn = 1'b1;
                break;
            end
        end
        start = 1'b0;
        writes = n_we - we0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w, d, nd, last, sw;
        for (int i = 0; i < N; i++) rom_mem[i] = 3'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_count", sprite_count, 0);
        chk("reset_writeEn", writeEn, 0);
        chk("reset_done", done, 0);
        #1 resetn = 1'b1;

        draw(10, 20, -1, -1, -1, w, d, nd);
        chk("t1_writes", w, 256);
        chk("t1_done_cycle", d, 513);
        chk("t1_done_pulses", nd, 1);
        chk("t1_first_x", fw_x, 10);
        chk("t1_first_y", fw_y, 20);
        chk("t1_count", sprite_count, 1);

        draw(312, 232, -1, -1, -1, w, d, nd);
        chk("t2_clipped_writes", w, 64);
        chk("t2_done_cycle", d, 513);
        chk("t2_count", sprite_count, 2);

        draw(0, 0, 5, 513, -1, w, d, nd);
        chk("t3_writes", w, 256);
        chk("t3_done_pulses", nd, 1);
        chk("t3_count", sprite_count, 3);
        chk("t3_idle_busy", busy, 0);

        draw(100, 100, -1, -1, 100, w, d, nd);
        draw(200, 100, -1, -1, -1, w, d, nd);
        chk("t4_writes", w, 256);
        chk("t4_done_cycle", d, 513);
        chk("t4_count", sprite_count, 1);

        for (int i = 0; i < N; i++) rom_mem[i] = (i < 100) ? 3'd0 : 3'(i % 7 + 1);
        draw(50, 50, -1, -1, -1, w, d, nd);
`ifdef SPRITE_TRANSPARENCY_EN
        chk("t5_key_writes", w, 156);
`else
        chk("t5_key_writes", w, 256);
`endif
        chk("t5_done_cycle", d, 513);
        chk("t5_count", sprite_count, 2);

        // Back-to-back small sprites with start held high.
        @(negedge clk);
        s_start = 1'b1;
        nd = 0; last = 0; sw = 0;
        for (int r = 0; r < 256*19 + 40 && nd < 256; r++) begin
            @(negedge clk);
            chk("s_count", s_count, nd % 256);
            if (s_writeEn === 1'b1) sw++;
            if (s_done === 1'b1) begin
                if (nd > 0) chk("s_done_gap", r - last, 19);
                last = r;
                nd++;
                if (nd == 256) s_start = 1'b0;
            end
        end
        chk("s_sprites", nd, 256);
`ifdef SPRITE_TRANSPARENCY_EN
        chk("s_writes", sw, 0);
`else
        chk("s_writes", sw, 2048);
`endif
        @(negedge clk);
        chk("s_count_wrapped", s_count, 0);
        chk("s_busy_end", s_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
